// File: rtl/light_sched_pkg.sv
// Shared definitions for the light-run scheduler: FSM state encoding, light
// patterns as seen on {ROJA, AMARILLA, VERDE}, and speed encoding.
package light_sched_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StLaunch = 3'd2,
    StRun    = 3'd3,
    StDoneSt = 3'd4
  } sched_state_e;

  // Light patterns, ordered {R, A, V}.
  localparam logic [2:0] PatInit  = 3'b100;
  localparam logic [2:0] PatFinal = 3'b111;

  localparam logic VelSlow = 1'b0;
  localparam logic VelFast = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The requester at ptr_i has the highest
// priority, then ptr_i+1, ... wrapping modulo N_REQ.
// Ports:
//   req_i  [N_REQ]       request vector
//   ptr_i  [log2 N_REQ]  index with current highest priority
//   gnt_o  [N_REQ]       one-hot winner (all zero when no request)
//   idx_o  [log2 N_REQ]  binary index of the winner (0 when no request)
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  int unsigned       pos;
  logic [IdxW-1:0]   pos_idx;
  logic              found;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    pos     = 0;
    pos_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos     = (int'(ptr_i) + i) % N_REQ;
      pos_idx = IdxW'(pos);
      if (!found && req_i[pos_idx]) begin
        found          = 1'b1;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/light_run_scheduler.sv
// Shares one traffic-light timing unit between N_REQ requesters. A round-robin
// winner gets the unit cleared, launched at its own speed, and watched until the
// unit shows the all-on final pattern (or the watchdog expires); the owner then
// gets a one-cycle DONE pulse (with ERR on watchdog abort).
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   REQ, REQ_VEL    [N_REQ]     level requests and per-requester speed
//   GNT, DONE       [N_REQ]     one-hot owner while busy, completion pulse
//   ERR, BUSY                   watchdog abort pulse, not-idle flag
//   UNIT_RESET/START/VEL        drive the light unit
//   UNIT_ROJA/AMARILLA/VERDE    light unit outputs
module light_run_scheduler
  import light_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] REQ,
  input  logic [N_REQ-1:0] REQ_VEL,
  output logic [N_REQ-1:0] GNT,
  output logic [N_REQ-1:0] DONE,
  output logic             ERR,
  output logic             BUSY,
  output logic             UNIT_RESET,
  output logic             UNIT_START,
  output logic             UNIT_VEL,
  input  logic             UNIT_ROJA,
  input  logic             UNIT_AMARILLA,
  input  logic             UNIT_VERDE
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_REQ - 1);

  sched_state_e    state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            vel_q, vel_d;
  logic            abort_q, abort_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]  arb_idx;
  logic [2:0]       pat;
  logic [N_REQ-1:0] owner_oh;

  assign pat = {UNIT_ROJA, UNIT_AMARILLA, UNIT_VERDE};

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req_i(REQ),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    vel_d   = vel_q;
    abort_d = abort_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|arb_gnt) begin
          idx_d   = arb_idx;
          vel_d   = REQ_VEL[arb_idx];
          abort_d = 1'b0;
          state_d = StClear;
        end
      end
      // Unit FINAL is sticky, so every run starts with a unit reset.
      StClear:  state_d = StLaunch;
      StLaunch: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
        // Normal completion wins over a watchdog expiring in the same cycle.
        if (pat == PatFinal) begin
          state_d = StDoneSt;
        end else if (cnt_q == CntLast) begin
          abort_d = 1'b1;
          state_d = StDoneSt;
        end
      end
      StDoneSt: begin
        ptr_d   = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      vel_q   <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vel_q   <= vel_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[idx_q] = 1'b1;
  end

  assign BUSY       = (state_q != StIdle);
  assign GNT        = BUSY ? owner_oh : '0;
  assign DONE       = (state_q == StDoneSt) ? owner_oh : '0;
  assign ERR        = (state_q == StDoneSt) && abort_q;
  assign UNIT_START = (state_q == StLaunch);
  assign UNIT_VEL   = (state_q == StLaunch) ? vel_q : VelSlow;
  assign UNIT_RESET = RESET || (state_q == StClear);

endmodule

// File: tb/tb_light_run_scheduler.sv
// Directed bench for light_run_scheduler with a behavioural light unit
// (21 yellow / 11 green cycles after START, then sticky all-on) and a stub
// mode that never reaches the final pattern.
module tb_light_run_scheduler;
  import light_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req_vel;
  logic [3:0] gnt, done;
  logic       err, busy, unit_reset, unit_start, unit_vel;
  logic       unit_roja, unit_amarilla, unit_verde;
  logic       stub_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  light_run_scheduler #(
    .N_REQ(4),
    .TIMEOUT(32)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .REQ(req),
    .REQ_VEL(req_vel),
    .GNT(gnt),
    .DONE(done),
    .ERR(err),
    .BUSY(busy),
    .UNIT_RESET(unit_reset),
    .UNIT_START(unit_start),
    .UNIT_VEL(unit_vel),
    .UNIT_ROJA(unit_roja),
    .UNIT_AMARILLA(unit_amarilla),
    .UNIT_VERDE(unit_verde)
  );

  // Light unit model: 0 init, 1 running, 2 final (sticky until reset).
  int         lu_st  = 0;
  int         lu_cnt = 0;
  logic       lu_vel = 1'b0;
  logic [2:0] lu_pat;

  always @(posedge clk) begin
    if (unit_reset) begin
      lu_st  <= 0;
      lu_cnt <= 0;
      lu_vel <= 1'b0;
    end else if (lu_st == 0) begin
      if (unit_start) begin
        lu_st  <= 1;
        lu_cnt <= 0;
        lu_vel <= unit_vel;
      end
    end else if (lu_st == 1) begin
      if (lu_cnt == ((lu_vel == VelFast) ? 10 : 20)) lu_st <= 2;
      else lu_cnt <= lu_cnt + 1;
    end
  end

  always_comb begin
    lu_pat = PatInit;
    if (lu_st == 1) lu_pat = (lu_vel == VelFast) ? 3'b001 : 3'b010;
    else if (lu_st == 2) lu_pat = PatFinal;
  end

  assign {unit_roja, unit_amarilla, unit_verde} = stub_en ? 3'b010 : lu_pat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle where the request is visible (cycle 0). Returns in
  // the DONE_ST cycle. drop_cyc > 0 clears REQ and inverts REQ_VEL at that cycle.
  task automatic run_one(input int idx, input logic vel, input int done_cyc,
                         input logic exp_err, input logic chk_lights, input int drop_cyc);
    logic [3:0] exp_g;
    logic       gnt_ok, done_ok;
    int         yel, grn;
    exp_g   = 4'b0001 << idx;
    gnt_ok  = 1'b1;
    done_ok = 1'b1;
    yel     = 0;
    grn     = 0;
    check("idle_gnt", gnt, 4'b0000);
    check("idle_busy", busy, 1'b0);
    for (int c = 1; c <= done_cyc; c++) begin
      tick();
      if (gnt !== exp_g) gnt_ok = 1'b0;
      if (c < done_cyc && (done !== 4'b0000 || err !== 1'b0)) done_ok = 1'b0;
      if ({unit_roja, unit_amarilla, unit_verde} == 3'b010) yel++;
      if ({unit_roja, unit_amarilla, unit_verde} == 3'b001) grn++;
      if (c == 1) begin
        check("clear_ureset", unit_reset, 1'b1);
        check("clear_ustart", unit_start, 1'b0);
      end
      if (c == 2) begin
        check("launch_ustart", unit_start, 1'b1);
        check("launch_uvel", unit_vel, vel);
        check("launch_ureset", unit_reset, 1'b0);
      end
      if (c == 3) begin
        check("run_ustart", unit_start, 1'b0);
        check("run_uvel", unit_vel, 1'b0);
      end
      if (c == drop_cyc) begin
        req     = 4'b0000;
        req_vel = ~req_vel;
      end
    end
    check("gnt_hold", gnt_ok, 1'b1);
    check("no_early_done", done_ok, 1'b1);
    check("done_pulse", done, exp_g);
    check("err_flag", err, exp_err);
    if (chk_lights) begin
      check("yellow_cycles", yel, vel ? 0 : 21);
      check("green_cycles", grn, vel ? 11 : 0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b0000;
    req_vel = 4'b0000;
    tick();
    tick();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_done", done, 4'b0000);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ustart", unit_start, 1'b0);
    check("rst_uvel", unit_vel, 1'b0);
    check("rst_ureset", unit_reset, 1'b1);
    rst = 1'b0;
    tick();
    check("post_rst_ureset", unit_reset, 1'b0);

    // All requesting, mixed speed: grants 0,1,2,3,0.
    req     = 4'b1111;
    req_vel = 4'b1010;
    run_one(0, 1'b0, 25, 1'b0, 1'b1, 0);
    tick();
    run_one(1, 1'b1, 15, 1'b0, 1'b1, 0);
    tick();
    run_one(2, 1'b0, 25, 1'b0, 1'b1, 0);
    tick();
    run_one(3, 1'b1, 15, 1'b0, 1'b1, 0);
    tick();
    run_one(0, 1'b0, 25, 1'b0, 1'b1, 0);
    req = 4'b0000;
    tick();
    check("done_once", done, 4'b0000);

    // Single slow requester 0.
    req     = 4'b0001;
    req_vel = 4'b0000;
    run_one(0, 1'b0, 25, 1'b0, 1'b1, 0);
    req = 4'b0000;
    tick();

    // Single fast requester 2.
    req     = 4'b0100;
    req_vel = 4'b0100;
    run_one(2, 1'b1, 15, 1'b0, 1'b1, 0);
    req = 4'b0000;
    tick();

    // Stubbed unit: watchdog abort, then a normal run.
    stub_en = 1'b1;
    req     = 4'b0010;
    req_vel = 4'b0010;
    run_one(1, 1'b1, 35, 1'b1, 1'b0, 0);
    stub_en = 1'b0;
    tick();
    run_one(1, 1'b1, 15, 1'b0, 1'b1, 0);
    req = 4'b0000;
    tick();
    check("err_once", err, 1'b0);

    // Reset during run cycle 5: pointer returns to 0.
    req     = 4'b0101;
    req_vel = 4'b0000;
    for (int c = 1; c <= 7; c++) tick();
    check("pre_rst_gnt", gnt, 4'b0100);
    rst = 1'b1;
    tick();
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_done", done, 4'b0000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ustart", unit_start, 1'b0);
    check("midrst_ureset", unit_reset, 1'b1);
    rst = 1'b0;
    run_one(0, 1'b0, 25, 1'b0, 1'b1, 0);
    req = 4'b0000;
    tick();

    // Request dropped and speed toggled mid-run.
    req     = 4'b0010;
    req_vel = 4'b0000;
    run_one(1, 1'b0, 25, 1'b0, 1'b1, 5);
    tick();
    check("drop_done_once", done, 4'b0000);
    check("drop_idle_busy", busy, 1'b0);
    tick();
    tick();
    check("drop_stay_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
